la_capture_ctrl: RTL

Capture controller for the 16-pin logic analyzer peripheral. It decodes configuration packets and runs a sample-rate prescaler. It arms on a mask/value trigger, streams a programmed number of samples as data packets, then emits one status packet. It sits between the peripheral-address demux (packet_in side) and the peripheral's upstream packet FIFO (packet_out side).

---
 rtl/la_pkg.sv | 51 +++++
 rtl/la_capture_ctrl_prescaler.sv | 38 +++
 rtl/la_capture_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/la_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : la_pkg
//  Description : Shared types and constants for the logic analyzer capture
//                controller: opcodes, FSM states, status codes and packet
//                field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package la_pkg;

  // Configuration opcodes carried in packet_in[23:20]
  typedef enum logic [3:0] {
    OP_SET_DIV   = 4'h1,
    OP_SET_COUNT = 4'h2,
    OP_SET_MASK  = 4'h3,
    OP_SET_VAL   = 4'h4,
    OP_ARM       = 4'h5,
    OP_ABORT     = 4'h6
  } opcode_t;

  // Capture controller states
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Status codes reported in the final status packet
  localparam logic [7:0] c_CODE_DONE  = 8'hD0;
  localparam logic [7:0] c_CODE_ABORT = 8'hAB;

  // nbytes field values for outgoing packets
  localparam logic [1:0] c_NBYTES_DATA   = 2'b10;
  localparam logic [1:0] c_NBYTES_STATUS = 2'b11;

  // Incoming packet field positions
  localparam int c_CFG_FLAG_BIT = 28;
  localparam int c_OP_HI        = 23;
  localparam int c_OP_LO        = 20;
  localparam int c_ARG_HI       = 19;

  // Assemble an outgoing packet {flag, nbytes, rsvd, payload}
  function automatic logic [28:0] make_pkt(input logic        flag,
                                           input logic [1:0]  nbytes,
                                           input logic [23:0] payload);
    return {flag, nbytes, 2'b00, payload};
  endfunction

endpackage
`default_nettype wire

// File: rtl/la_capture_ctrl_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : la_prescaler
//  Description : Sample-rate prescaler. Counts 0..div_max while enabled and
//                pulses o_tick on the terminal count, giving a tick period of
//                div_max+1 cycles. Holds its count while disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module la_prescaler #(
  parameter int DIV_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [DIV_W-1:0] i_div_max,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == i_div_max);
  assign o_tick = i_enable && w_wrap;

  // Free-running divider: clear has priority, reload to zero on terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_wrap ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/la_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : la_capture_ctrl
//  Description : Logic analyzer capture controller. Decodes configuration
//                packets, waits for a mask/value trigger, streams samples as
//                data packets and finishes with a status packet.
//  Revision    : 1.0 - initial release
// ============================================================================
module la_capture_ctrl import la_pkg::*; #(
  parameter int WIDTH         = 32,
  parameter int PERIPH_ADDR_W = 3,
  parameter int PINS          = 16,
  parameter int DIV_W         = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           packet_in,
  input  logic                       packet_in_valid,
  input  logic [PINS-1:0]            pin_vals,
  output logic [WIDTH-PERIPH_ADDR_W-1:0] packet_out,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic                       busy
);

  localparam int OUT_W = WIDTH - PERIPH_ADDR_W;

  // Pin synchronizer
  logic [PINS-1:0]  r_sync1, r_sync2;

  // Configuration and run counters
  logic [DIV_W-1:0] r_div_max;
  logic [15:0]      r_sample_count;
  logic [PINS-1:0]  r_trig_mask, r_trig_val;
  logic [15:0]      r_overrun;
  logic [15:0]      r_taken;
  logic             r_abort;

  // FSM
  state_t           r_state, w_next_state;

  // Output register
  logic [OUT_W-1:0] r_pkt;
  logic             r_valid;
  logic             r_stat_pend;

  // Decode and control
  logic             w_cmd, w_in_idle, w_arm, w_abort, w_accept, w_trig_hit;
  logic [3:0]       w_op;
  logic [19:0]      w_arg;
  logic [15:0]      w_taken_next;
  logic             w_last;
  logic             w_tick, w_pre_clear, w_pre_en;
  logic             w_capture, w_status_load, w_load_sample, w_drop;
  logic             w_unused;

  assign w_cmd        = packet_in_valid && packet_in[c_CFG_FLAG_BIT];
  assign w_op         = packet_in[c_OP_HI:c_OP_LO];
  assign w_arg        = packet_in[c_ARG_HI:0];
  assign w_in_idle    = (r_state == S_IDLE);
  assign w_arm        = w_cmd && (w_op == OP_ARM) && w_in_idle;
  assign w_abort      = w_cmd && (w_op == OP_ABORT) && !w_in_idle;
  assign w_accept     = r_valid && data_ready;
  assign w_trig_hit   = ((r_sync2 & r_trig_mask) == (r_trig_val & r_trig_mask));
  assign w_taken_next = r_taken + 16'd1;
  assign w_last       = (r_sample_count != 16'd0) && (w_taken_next == r_sample_count);
  // A capture lands in the output register if it is empty or being emptied
  assign w_load_sample = w_capture && (!r_valid || data_ready);
  assign w_drop        = w_capture && r_valid && !data_ready;
  assign w_unused      = ^{packet_in[WIDTH-1:c_CFG_FLAG_BIT+1], packet_in[c_CFG_FLAG_BIT-1:c_OP_HI+1]};

  assign packet_out = r_pkt;
  assign data_valid = r_valid;

  la_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_pre_clear),
    .i_enable  (w_pre_en),
    .i_div_max (r_div_max),
    .o_tick    (w_tick)
  );

  // Two-flop synchronizer on the asynchronous pin inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pin_vals;
      r_sync2 <= r_sync1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state, prescaler control and capture/status strobes; ABORT beats a tick
  always_comb begin
    w_next_state  = r_state;
    busy          = (r_state != S_IDLE);
    w_pre_clear   = 1'b0;
    w_pre_en      = 1'b0;
    w_capture     = 1'b0;
    w_status_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arm) begin
          w_next_state = S_ARMED;
          w_pre_clear  = 1'b1;
        end
      end
      S_ARMED: begin
        w_pre_en = 1'b1;
        if (w_abort) begin
          w_next_state = S_DONE;
        end else if (w_tick && w_trig_hit) begin
          w_capture    = 1'b1;
          w_next_state = w_last ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_pre_en = 1'b1;
        if (w_abort) begin
          w_next_state = S_DONE;
        end else if (w_tick) begin
          w_capture = 1'b1;
          if (w_last) w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (!r_valid) begin
          w_status_load = 1'b1;
        end else if (r_stat_pend && data_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Configuration writes (IDLE only) and per-run counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_max      <= '0;
      r_sample_count <= '0;
      r_trig_mask    <= '0;
      r_trig_val     <= '0;
      r_overrun      <= '0;
      r_taken        <= '0;
      r_abort        <= 1'b0;
    end else begin
      if (w_cmd && w_in_idle) begin
        case (w_op)
          OP_SET_DIV:   r_div_max      <= w_arg[DIV_W-1:0];
          OP_SET_COUNT: r_sample_count <= w_arg[15:0];
          OP_SET_MASK:  r_trig_mask    <= w_arg[PINS-1:0];
          OP_SET_VAL:   r_trig_val     <= w_arg[PINS-1:0];
          default:      ;
        endcase
      end
      if (w_arm) begin
        r_overrun <= '0;
        r_taken   <= '0;
        r_abort   <= 1'b0;
      end
      if (w_capture) begin
        r_taken <= w_taken_next;
        if (w_drop && (r_overrun != 16'hFFFF)) r_overrun <= r_overrun + 16'd1;
      end
      // An ABORT arriving after normal completion leaves the completion code alone
      if (w_abort && (r_state != S_DONE)) r_abort <= 1'b1;
    end
  end

  // Output register: sample load, status load, or drain on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt       <= '0;
      r_valid     <= 1'b0;
      r_stat_pend <= 1'b0;
    end else if (w_load_sample) begin
      r_pkt       <= OUT_W'(make_pkt(1'b0, c_NBYTES_DATA, 24'(r_sync2)));
      r_valid     <= 1'b1;
      r_stat_pend <= 1'b0;
    end else if (w_status_load) begin
      r_pkt       <= OUT_W'(make_pkt(1'b1, c_NBYTES_STATUS,
                                     {(r_abort ? c_CODE_ABORT : c_CODE_DONE), r_overrun}));
      r_valid     <= 1'b1;
      r_stat_pend <= 1'b1;
    end else if (w_accept) begin
      r_valid     <= 1'b0;
      r_stat_pend <= 1'b0;
    end
  end

endmodule
`default_nettype wire
